// File: rtl/wishbone_mem_slave.sv
// Wishbone classic-cycle slave: DEPTH x 64-bit memory with a programmable number of wait states.
// Ack and read data are registered; a transfer is only re-armed after stb drops.
//
// state  | meaning
// S_IDLE | waiting for cyc&stb, request latched on accept
// S_WAIT | counting down wait states, abort if cyc or stb drops
// S_ACK  | ack_o high this cycle, write committed at end of cycle
// S_HOLD | master still asserting stb after ack, no further ack
module wishbone_mem_slave #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned ADDR_LSB    = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic [63:0] data_i,
   input  logic        we_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   output logic [63:0] data_o,
   output logic        ack_o,
   output logic        err_o
);
   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam logic [63:0] OOR_DATA  = 64'hDEAD_BEEF_DEAD_BEEF;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept, go_ack;

   logic [63:0] mem [DEPTH];

   logic [31:0]   offset, idx_full;
   logic          in_range_dec;
   logic [AW-1:0] lat_idx, rd_idx;
   logic          lat_we, lat_in_range, rd_we, rd_in_range;
   logic [63:0]   lat_data, rd_word;

   assign offset       = addr_i - BASE_ADDR;
   assign idx_full     = offset >> ADDR_LSB;
   assign in_range_dec = (addr_i >= BASE_ADDR) && (idx_full < DEPTH);

   // With zero wait states the ack edge is the accept edge, so bypass the latches.
   assign rd_idx      = accept ? idx_full[AW-1:0] : lat_idx;
   assign rd_we       = accept ? we_i : lat_we;
   assign rd_in_range = accept ? in_range_dec : lat_in_range;
   assign rd_word     = mem[rd_idx];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      go_ack    = 1'b0;
      case (state)
         S_IDLE: begin
            if (cyc_i && stb_i) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nxt = S_ACK;
                  go_ack    = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!(cyc_i && stb_i)) begin
               state_nxt = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_nxt = S_ACK;
               go_ack    = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_ACK:   state_nxt = S_HOLD;
         S_HOLD:  if (!stb_i) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state        <= S_IDLE;
         cnt          <= 4'd0;
         ack_o        <= 1'b0;
         err_o        <= 1'b0;
         data_o       <= 64'd0;
         lat_idx      <= '0;
         lat_we       <= 1'b0;
         lat_in_range <= 1'b0;
         lat_data     <= 64'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ack_o <= go_ack;
         err_o <= go_ack && !rd_in_range;
         if (go_ack && !rd_we)
            data_o <= rd_in_range ? rd_word : OOR_DATA;
         if (accept) begin
            lat_idx      <= idx_full[AW-1:0];
            lat_we       <= we_i;
            lat_in_range <= in_range_dec;
            lat_data     <= data_i;
         end
      end
   end

   // Memory is never cleared; a reset during the ack cycle suppresses the write.
   always_ff @(posedge clk_i) begin
      if (rst_i && state == S_ACK && lat_we && lat_in_range)
         mem[lat_idx] <= lat_data;
   end

endmodule

// File: tb/tb_wishbone_mem_slave.sv
// Randomized bench for wishbone_mem_slave against an array-based reference memory.
// Two instances: index 0 has no wait states and a non-zero base, index 1 uses the defaults.
module tb_wishbone_mem_slave;
   localparam logic [31:0] BASE0 = 32'h0000_1000;
   localparam int          DEP0  = 16;
   localparam int          DEP1  = 256;
   localparam logic [63:0] DEAD  = 64'hDEAD_BEEF_DEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic        we;
   logic        cyc [2];
   logic        stb [2];
   logic [63:0] dout [2];
   logic        ack [2];
   logic        err [2];

   always #5 clk = ~clk;

   wishbone_mem_slave #(.DEPTH(DEP0), .WAIT_STATES(0), .BASE_ADDR(BASE0), .ADDR_LSB(3)) dut_w0 (
      .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata), .we_i(we),
      .cyc_i(cyc[0]), .stb_i(stb[0]), .data_o(dout[0]), .ack_o(ack[0]), .err_o(err[0]));

   wishbone_mem_slave #(.DEPTH(DEP1), .WAIT_STATES(2), .BASE_ADDR(32'h0), .ADDR_LSB(3)) dut_w2 (
      .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata), .we_i(we),
      .cyc_i(cyc[1]), .stb_i(stb[1]), .data_o(dout[1]), .ack_o(ack[1]), .err_o(err[1]));

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] ref_mem [2][DEP1];
   logic [63:0] ref_dout [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic int depth_of(input int u);
      return (u == 0) ? DEP0 : DEP1;
   endfunction

   function automatic logic [31:0] base_of(input int u);
      return (u == 0) ? BASE0 : 32'h0;
   endfunction

   function automatic int lat_of(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   // One complete transfer: request, wait for ack, hold stb for `extra` cycles, release.
   task automatic do_xfer(input int u, input logic [31:0] a, input logic w,
                          input logic [63:0] d, input int extra);
      int          lat, extra_acks, idx;
      logic        e, unstable, inr;
      logic [63:0] rd, exp_rd;
      logic [31:0] off;
      lat = -1; e = 1'b0; rd = 64'd0; extra_acks = 0; unstable = 1'b0;
      off = a - base_of(u);
      inr = (a >= base_of(u)) && ((off / 8) < 32'(depth_of(u)));
      idx = inr ? int'(off / 8) : 0;

      @(negedge clk);
      addr = a; wdata = d; we = w; cyc[u] = 1'b1; stb[u] = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 40; i++) begin
         #1;
         if (ack[u]) begin
            lat = i; e = err[u]; rd = dout[u];
            break;
         end
         @(posedge clk);
      end
      for (int i = 0; i < extra; i++) begin
         @(posedge clk); #1;
         if (ack[u]) extra_acks++;
         if (dout[u] !== rd) unstable = 1'b1;
      end
      @(posedge clk); #1;
      if (ack[u]) extra_acks++;
      if (dout[u] !== rd) unstable = 1'b1;
      cyc[u] = 1'b0; stb[u] = 1'b0;
      @(posedge clk);

      check($sformatf("latency u%0d a=%h", u, a), 64'(lat), 64'(lat_of(u)));
      check($sformatf("err u%0d a=%h", u, a), 64'(e), 64'(!inr));
      check($sformatf("single_ack u%0d a=%h", u, a), 64'(extra_acks), 64'd0);
      check($sformatf("hold_stable u%0d a=%h", u, a), 64'(unstable), 64'd0);
      if (w) begin
         check($sformatf("write_keeps_data u%0d a=%h", u, a), rd, ref_dout[u]);
         if (inr) ref_mem[u][idx] = d;
      end else begin
         exp_rd = inr ? ref_mem[u][idx] : DEAD;
         check($sformatf("read_data u%0d a=%h", u, a), rd, exp_rd);
         ref_dout[u] = exp_rd;
      end
   endtask

   // Write on the wait-state instance, then drop stb (or cyc) during the wait phase.
   task automatic abort_xfer(input logic [31:0] a, input logic [63:0] d, input logic drop_cyc);
      int acks;
      acks = 0;
      @(negedge clk);
      addr = a; wdata = d; we = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      if (drop_cyc) cyc[1] = 1'b0;
      else stb[1] = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack[1]) acks++;
      end
      cyc[1] = 1'b0; stb[1] = 1'b0;
      check($sformatf("abort_no_ack cyc=%0d", drop_cyc), 64'(acks), 64'd0);
      check($sformatf("abort_data_o cyc=%0d", drop_cyc), dout[1], ref_dout[1]);
   endtask

   task automatic reset_during_write(input logic [31:0] a, input logic [63:0] d);
      int acks;
      acks = 0;
      @(negedge clk);
      addr = a; wdata = d; we = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("reset_mid_ack", 64'(ack[1]), 64'd0);
      check("reset_mid_data", dout[1], 64'd0);
      rst_n = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
      ref_dout[0] = 64'd0; ref_dout[1] = 64'd0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ack[1] || ack[0]) acks++;
      end
      check("reset_no_late_ack", 64'(acks), 64'd0);
   endtask

   function automatic logic [31:0] rand_addr(input int u);
      logic [31:0] b, dep8;
      b = base_of(u);
      dep8 = 32'(depth_of(u) * 8);
      case ($urandom_range(0, 7))
         0: return b + dep8 + 32'($urandom_range(0, 64)) * 8;
         1: return (u == 0) ? 32'($urandom_range(0, 32'h0FFF))
                            : b + 32'($urandom_range(0, depth_of(u) - 1)) * 8;
         default: return b + 32'($urandom_range(0, depth_of(u) - 1)) * 8
                           + 32'($urandom_range(0, 7));
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int u;
      rst_n = 1'b0; addr = 32'd0; wdata = 64'd0; we = 1'b0;
      cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
      ref_dout[0] = 64'd0; ref_dout[1] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_ack u%0d", i), 64'(ack[i]), 64'd0);
         check($sformatf("reset_err u%0d", i), 64'(err[i]), 64'd0);
         check($sformatf("reset_data u%0d", i), dout[i], 64'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);

      // Known contents everywhere so every later read has a defined expectation.
      for (int i = 0; i < DEP1; i++) do_xfer(1, 32'(i * 8), 1'b1, {$urandom, $urandom}, 0);
      for (int i = 0; i < DEP0; i++) do_xfer(0, BASE0 + 32'(i * 8), 1'b1, {$urandom, $urandom}, 0);

      do_xfer(1, 32'h10, 1'b1, 64'h1122_3344_5566_7788, 0);
      do_xfer(1, 32'h10, 1'b0, 64'd0, 0);
      check("directed_read_0x10", ref_dout[1], 64'h1122_3344_5566_7788);
      do_xfer(1, 32'h10, 1'b0, 64'd0, 5);
      do_xfer(1, 32'h800, 1'b0, 64'd0, 0);
      do_xfer(1, 32'h800, 1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 0);
      do_xfer(1, 32'h0, 1'b0, 64'd0, 0);

      abort_xfer(32'h20, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
      do_xfer(1, 32'h20, 1'b0, 64'd0, 0);
      abort_xfer(32'h30, 64'hBAD1_BAD1_BAD1_BAD1, 1'b1);
      do_xfer(1, 32'h30, 1'b0, 64'd0, 0);

      reset_during_write(32'h28, 64'hFEED_FACE_CAFE_F00D);
      do_xfer(1, 32'h28, 1'b0, 64'd0, 0);

      do_xfer(0, BASE0 + 32'h18, 1'b1, 64'h0123_4567_89AB_CDEF, 0);
      do_xfer(0, BASE0 + 32'h18, 1'b0, 64'd0, 0);
      do_xfer(0, BASE0 - 32'h8, 1'b0, 64'd0, 0);
      do_xfer(0, BASE0 + 32'(DEP0 * 8), 1'b1, 64'h7777_7777_7777_7777, 2);
      do_xfer(0, BASE0, 1'b0, 64'd0, 1);

      for (int n = 0; n < 120; n++) begin
         u = int'($urandom_range(0, 1));
         do_xfer(u, rand_addr(u), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
